// File: rtl/apb_spi_slave.sv
// apb_spi_slave: APB-programmable SPI slave (mode 0, MSB first, 8-bit frames).
// The SPI pins are oversampled in the PCLK domain. Bytes pass through TX/RX FIFOs.
// An 8-bit register file with a level interrupt exposes them to the SoC.

// Byte FIFO shared by the TX and RX paths; the caller qualifies push/pop.
module apb_spi_slave_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       PCLK,
   input  logic       PRESET,
   input  logic       flush,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] wdata,
   output logic [7:0] head,
   output logic       empty,
   output logic       full
);
   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(DEPTH));

   // Pointer and occupancy bookkeeping; a flush overrides any same-cycle push/pop.
   // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge PCLK) begin
      if (PRESET || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage write port.
   // NOTE: the array has no reset; the pointers alone decide which entries are valid.
   always_ff @(posedge PCLK) begin
      if (push) mem[wr_ptr] <= wdata;
   end
endmodule

module apb_spi_slave #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       PCLK,
   input  logic       PRESET,
   input  logic [7:0] PADDR,
   input  logic       PWRITE,
   input  logic       PSEL,
   input  logic       PENABLE,
   input  logic [7:0] PWDATA,
   output logic [7:0] PRDATA,
   output logic       PREADY,
   output logic       SPI_INT,
   input  logic       scs_i,
   input  logic       sck_i,
   input  logic       mosi_i,
   output logic       miso_o,
   output logic       miso_oe
);
   localparam logic [4:0] REG_CTRL   = 5'd0;
   localparam logic [4:0] REG_STAT   = 5'd1;
   localparam logic [4:0] REG_RXDATA = 5'd2;
   localparam logic [4:0] REG_TXDATA = 5'd3;

   // APB decode
   logic       apb_access;
   logic [4:0] reg_sel;
   logic       ctrl_wr, stat_wr, txd_wr, rxd_rd;
   logic       tx_flush, rx_flush;
   logic       addr_unused;

   // Control / status
   logic [3:0] ctrl_q;          // {ERRIE, TXIE, RXIE, EN}
   logic       en, rxie, txie, errie;
   logic       ovr, udr, busy;
   logic [7:0] stat_byte;

   // Synchronisers: [0] first stage, [1] synced value, [2] edge-detect history
   logic [2:0] scs_pipe, sck_pipe, mosi_pipe;
   logic       scs_fall, scs_rise, sck_rise, sck_fall;

   // SPI engine
   logic       active, first_edge;
   logic [2:0] bit_cnt;
   logic [7:0] tx_shift;
   logic [6:0] rx_shift;
   logic       frame_start, abort, rise_evt, fall_evt;
   logic       tx_load, udr_set, rx_push_req, ovr_set;

   // FIFO handshakes
   logic       tx_push, tx_pop, tx_empty, tx_full;
   logic       rx_push, rx_pop, rx_empty, rx_full;
   logic [7:0] tx_head, rx_head;

   assign apb_access  = PSEL & PENABLE;
   assign PREADY      = apb_access;
   assign reg_sel     = PADDR[7:3];
   assign addr_unused = ^PADDR[2:0];
   assign ctrl_wr     = apb_access &  PWRITE & (reg_sel == REG_CTRL);
   assign stat_wr     = apb_access &  PWRITE & (reg_sel == REG_STAT);
   assign txd_wr      = apb_access &  PWRITE & (reg_sel == REG_TXDATA);
   assign rxd_rd      = apb_access & ~PWRITE & (reg_sel == REG_RXDATA);
   assign tx_flush    = ctrl_wr & PWDATA[6];
   assign rx_flush    = ctrl_wr & PWDATA[7];

   assign en    = ctrl_q[0];
   assign rxie  = ctrl_q[1];
   assign txie  = ctrl_q[2];
   assign errie = ctrl_q[3];

   assign scs_fall = scs_pipe[2] & ~scs_pipe[1];
   assign scs_rise = ~scs_pipe[2] & scs_pipe[1];
   assign sck_rise = ~sck_pipe[2] & sck_pipe[1];
   assign sck_fall = sck_pipe[2] & ~sck_pipe[1];

   // Disabling mid-frame is treated exactly like the master deselecting us.
   assign frame_start = en & scs_fall;
   assign abort       = active & (scs_rise | ~en);
   assign rise_evt    = active & ~abort & sck_rise;
   assign fall_evt    = active & ~abort & sck_fall;

   // TX byte loads: at frame start, and on the falling edge that closes each byte.
   assign tx_load = frame_start | (fall_evt & (bit_cnt == 3'd0) & ~first_edge);
   assign tx_pop  = tx_load & ~tx_empty;
   assign udr_set = tx_load & tx_empty;
   assign tx_push = txd_wr & (~tx_full | tx_pop) & ~tx_flush;

   assign rx_pop      = rxd_rd & ~rx_empty;
   assign rx_push_req = rise_evt & (bit_cnt == 3'd7);
   assign rx_push     = rx_push_req & (~rx_full | rx_pop) & ~rx_flush;
   assign ovr_set     = rx_push_req & rx_full & ~rx_pop & ~rx_flush;

   assign busy      = en & ~scs_pipe[1];
   assign stat_byte = {1'b0, busy, udr, ovr, tx_full, tx_empty, rx_full, ~rx_empty};

   assign miso_oe = active;
   assign miso_o  = active & tx_shift[7];

   apb_spi_slave_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .PCLK   (PCLK),
      .PRESET (PRESET),
      .flush  (tx_flush),
      .push   (tx_push),
      .pop    (tx_pop),
      .wdata  (PWDATA),
      .head   (tx_head),
      .empty  (tx_empty),
      .full   (tx_full)
   );

   apb_spi_slave_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .PCLK   (PCLK),
      .PRESET (PRESET),
      .flush  (rx_flush),
      .push   (rx_push),
      .pop    (rx_pop),
      .wdata  ({rx_shift, mosi_pipe[2]}),
      .head   (rx_head),
      .empty  (rx_empty),
      .full   (rx_full)
   );

   // Two-flop synchronisers plus a history flop; scs idles high so reset gives no false edge.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         scs_pipe  <= 3'b111;
         sck_pipe  <= 3'b000;
         mosi_pipe <= 3'b000;
      end else begin
         scs_pipe  <= {scs_pipe[1:0], scs_i};
         sck_pipe  <= {sck_pipe[1:0], sck_i};
         mosi_pipe <= {mosi_pipe[1:0], mosi_i};
      end
   end

   // SPI bit engine: frame start/abort, RX shift on rising SCK, TX shift/load on falling SCK.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         active     <= 1'b0;
         first_edge <= 1'b0;
         bit_cnt    <= 3'd0;
         tx_shift   <= 8'h00;
         rx_shift   <= 7'h00;
      end else if (frame_start) begin
         active     <= 1'b1;
         first_edge <= 1'b1;
         bit_cnt    <= 3'd0;
         tx_shift   <= tx_empty ? 8'hFF : tx_head;
      end else if (abort) begin
         active     <= 1'b0;
         first_edge <= 1'b0;
         bit_cnt    <= 3'd0;
         tx_shift   <= 8'h00;
         rx_shift   <= 7'h00;
      end else begin
         if (rise_evt) begin
            rx_shift   <= {rx_shift[5:0], mosi_pipe[2]};
            bit_cnt    <= bit_cnt + 3'd1;
            first_edge <= 1'b0;
         end
         if (fall_evt) begin
            first_edge <= 1'b0;
            if (bit_cnt != 3'd0)  tx_shift <= {tx_shift[6:0], 1'b0};
            else if (!first_edge) tx_shift <= tx_empty ? 8'hFF : tx_head;
         end
      end
   end

   // Control register and sticky error flags (set wins over a same-cycle clear).
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         ctrl_q <= 4'h0;
         ovr    <= 1'b0;
         udr    <= 1'b0;
      end else begin
         if (ctrl_wr) ctrl_q <= PWDATA[3:0];
         ovr <= (ovr & ~(stat_wr & PWDATA[4])) | ovr_set;
         udr <= (udr & ~(stat_wr & PWDATA[5])) | udr_set;
      end
   end

   // Registered interrupt, one PCLK behind its conditions.
   always_ff @(posedge PCLK) begin
      if (PRESET) SPI_INT <= 1'b0;
      else        SPI_INT <= en & ((rxie & ~rx_empty) | (txie & tx_empty) | (errie & (ovr | udr)));
   end

   // Read mux, driven only during the access phase.
   always_comb begin
      PRDATA = 8'h00;  // NOTE: default first so no path leaves PRDATA unassigned (no latch).
      if (apb_access) begin
         case (reg_sel)
            REG_CTRL:   PRDATA = {4'h0, ctrl_q};
            REG_STAT:   PRDATA = stat_byte;
            REG_RXDATA: PRDATA = rx_empty ? 8'h00 : rx_head;
            default:    PRDATA = 8'h00;
         endcase
      end
   end
endmodule

// File: tb/tb_apb_spi_slave.sv
// tb_apb_spi_slave: directed bench for apb_spi_slave with a transaction-level model
// (byte queues and flags) and a per-cycle compare process for miso_oe/SPI_INT.
module tb_apb_spi_slave;
   localparam int DEPTH = 4;
   localparam logic [7:0] A_CTRL = 8'h00;
   localparam logic [7:0] A_STAT = 8'h08;
   localparam logic [7:0] A_RX   = 8'h10;
   localparam logic [7:0] A_TX   = 8'h18;

   logic       PCLK = 1'b0;
   logic       PRESET = 1'b1;
   logic [7:0] PADDR = 8'h00;
   logic       PWRITE = 1'b0;
   logic       PSEL = 1'b0;
   logic       PENABLE = 1'b0;
   logic [7:0] PWDATA = 8'h00;
   logic [7:0] PRDATA;
   logic       PREADY;
   logic       SPI_INT;
   logic       scs_i = 1'b1;
   logic       sck_i = 1'b0;
   logic       mosi_i = 1'b0;
   logic       miso_o;
   logic       miso_oe;

   int n_checks = 0;
   int n_fail = 0;
   int busy_depth = 1;

   // Model state
   logic [7:0] m_tx_q[$];
   logic [7:0] m_rx_q[$];
   logic [7:0] m_miso_q[$];
   logic [3:0] m_ctrl = 4'h0;
   logic       m_ovr = 1'b0;
   logic       m_udr = 1'b0;
   logic       m_scs_low = 1'b0;
   logic       m_in_frame = 1'b0;
   logic       m_first = 1'b0;
   int         m_cnt = 0;
   logic [7:0] m_cur_tx = 8'h00;
   logic [7:0] m_rx_acc = 8'h00;
   logic [7:0] m_got = 8'h00;

   apb_spi_slave #(.FIFO_DEPTH(DEPTH)) dut (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .PADDR   (PADDR),
      .PWRITE  (PWRITE),
      .PSEL    (PSEL),
      .PENABLE (PENABLE),
      .PWDATA  (PWDATA),
      .PRDATA  (PRDATA),
      .PREADY  (PREADY),
      .SPI_INT (SPI_INT),
      .scs_i   (scs_i),
      .sck_i   (sck_i),
      .mosi_i  (mosi_i),
      .miso_o  (miso_o),
      .miso_oe (miso_oe)
   );

   always #5 PCLK = ~PCLK;

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic model_int();
      return m_ctrl[0] && ((m_ctrl[1] && m_rx_q.size() > 0) ||
                           (m_ctrl[2] && m_tx_q.size() == 0) ||
                           (m_ctrl[3] && (m_ovr || m_udr)));
   endfunction

   function automatic logic [7:0] model_stat();
      return {1'b0, m_scs_low & m_ctrl[0], m_udr, m_ovr,
              logic'(m_tx_q.size() == DEPTH), logic'(m_tx_q.size() == 0),
              logic'(m_rx_q.size() == DEPTH), logic'(m_rx_q.size() > 0)};
   endfunction

   function automatic logic [7:0] model_read(input logic [7:0] addr);
      case (addr[7:3])
         5'd0:    return {4'h0, m_ctrl};
         5'd1:    return model_stat();
         5'd2:    return (m_rx_q.size() > 0) ? m_rx_q[0] : 8'h00;
         default: return 8'h00;
      endcase
   endfunction

   task automatic m_load();
      if (m_tx_q.size() > 0) m_cur_tx = m_tx_q.pop_front();
      else begin
         m_cur_tx = 8'hFF;
         m_udr = 1'b1;
      end
   endtask

   task automatic model_write(input logic [7:0] addr, input logic [7:0] d);
      case (addr[7:3])
         5'd0: begin
            m_ctrl = d[3:0];
            if (d[6]) m_tx_q.delete();
            if (d[7]) m_rx_q.delete();
            if (!m_ctrl[0]) begin
               m_in_frame = 1'b0;
               m_cnt = 0;
            end
         end
         5'd1: begin
            if (d[4]) m_ovr = 1'b0;
            if (d[5]) m_udr = 1'b0;
         end
         5'd3: if (m_tx_q.size() < DEPTH) m_tx_q.push_back(d);
         default: ;
      endcase
   endtask

   task automatic apb_write(input logic [7:0] addr, input logic [7:0] data);
      busy_depth++;
      @(posedge PCLK); #1;
      PSEL = 1'b1; PWRITE = 1'b1; PADDR = addr; PWDATA = data; PENABLE = 1'b0;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(posedge PCLK);
      model_write(addr, data);
      #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      repeat (2) @(posedge PCLK);
      busy_depth--;
   endtask

   task automatic apb_read(input logic [7:0] addr, output logic [7:0] data);
      logic [7:0] exp;
      busy_depth++;
      @(posedge PCLK); #1;
      PSEL = 1'b1; PWRITE = 1'b0; PADDR = addr; PENABLE = 1'b0;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(negedge PCLK);
      data = PRDATA;
      exp = model_read(addr);
      check("pready", {7'd0, PREADY}, 8'h01);
      check($sformatf("prdata@%02h", addr), data, exp);
      @(posedge PCLK);
      if (addr[7:3] == 5'd2 && m_rx_q.size() > 0) void'(m_rx_q.pop_front());
      #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      repeat (2) @(posedge PCLK);
      busy_depth--;
   endtask

   task automatic spi_begin();
      busy_depth++;
      @(posedge PCLK); #1;
      scs_i = 1'b0;
      m_scs_low = 1'b1;
      m_miso_q.delete();
      if (m_ctrl[0]) begin
         m_in_frame = 1'b1;
         m_cnt = 0;
         m_first = 1'b1;
         m_load();
      end
      repeat (6) @(posedge PCLK);
      busy_depth--;
      repeat (2) @(posedge PCLK);
   endtask

   task automatic spi_end();
      busy_depth++;
      @(posedge PCLK); #1;
      scs_i = 1'b1;
      m_scs_low = 1'b0;
      m_in_frame = 1'b0;
      m_cnt = 0;
      repeat (6) @(posedge PCLK);
      busy_depth--;
      repeat (2) @(posedge PCLK);
   endtask

   // One SCK period; optionally an RXDATA read whose commit edge meets the rising-edge action.
   task automatic spi_bit(input logic b, input logic with_read, output logic [7:0] rd);
      rd = 8'h00;
      #1;
      mosi_i = b;
      repeat (8) @(posedge PCLK);
      #1;
      busy_depth++;
      m_got = {m_got[6:0], miso_o};
      sck_i = 1'b1;
      if (with_read) apb_read(A_RX, rd);
      if (m_in_frame) begin
         m_rx_acc = {m_rx_acc[6:0], b};
         m_cnt++;
         m_first = 1'b0;
         if (m_cnt == 8) begin
            check("miso_byte", m_got, m_cur_tx);
            m_miso_q.push_back(m_got);
            if (m_rx_q.size() < DEPTH) m_rx_q.push_back(m_rx_acc);
            else m_ovr = 1'b1;
            m_cnt = 0;
         end
      end
      repeat (6) @(posedge PCLK);
      busy_depth--;
      repeat (2) @(posedge PCLK);
      #1;
      busy_depth++;
      sck_i = 1'b0;
      if (m_in_frame) begin
         if (m_cnt == 0 && !m_first) m_load();
         m_first = 1'b0;
      end
      repeat (6) @(posedge PCLK);
      busy_depth--;
   endtask

   task automatic spi_byte(input logic [7:0] b);
      logic [7:0] unused_rd;
      for (int i = 7; i >= 0; i--) spi_bit(b[i], 1'b0, unused_rd);
   endtask

   // Per-cycle compare of the continuously meaningful outputs against the model.
   always @(negedge PCLK) begin
      if (!PRESET && busy_depth == 0) begin
         check("miso_oe", {7'd0, miso_oe}, {7'd0, m_in_frame});
         check("spi_int", {7'd0, SPI_INT}, {7'd0, model_int()});
         if (!m_in_frame) check("miso_idle", {7'd0, miso_o}, 8'h00);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] d;
      logic [7:0] bits5;

      // Reset state
      repeat (4) @(posedge PCLK);
      @(negedge PCLK);
      check("rst_miso_oe", {7'd0, miso_oe}, 8'h00);
      check("rst_miso_o", {7'd0, miso_o}, 8'h00);
      check("rst_spi_int", {7'd0, SPI_INT}, 8'h00);
      check("rst_pready", {7'd0, PREADY}, 8'h00);
      check("rst_prdata", PRDATA, 8'h00);
      @(posedge PCLK); #1;
      PRESET = 1'b0;
      repeat (2) @(posedge PCLK);
      busy_depth = 0;
      apb_read(A_STAT, d);   check("stat_reset", d, 8'h04);
      apb_read(A_CTRL, d);   check("ctrl_reset", d, 8'h00);
      apb_read(A_RX, d);     check("rx_reset", d, 8'h00);

      // Two-byte frame
      apb_write(A_CTRL, 8'h01);
      apb_write(A_TX, 8'hA5);
      apb_write(A_TX, 8'h3C);
      apb_read(A_STAT, d);   check("stat_tx2", d, 8'h00);
      spi_begin();
      spi_byte(8'h5A);
      spi_byte(8'hC3);
      spi_end();
      check("miso_b0", (m_miso_q.size() > 0) ? m_miso_q[0] : 8'h00, 8'hA5);
      check("miso_b1", (m_miso_q.size() > 1) ? m_miso_q[1] : 8'h00, 8'h3C);
      apb_read(A_STAT, d);   check("txe_end", {7'd0, d[2]}, 8'h01);
      apb_read(A_RX, d);     check("rx_5a", d, 8'h5A);
      apb_read(A_RX, d);     check("rx_c3", d, 8'hC3);
      apb_read(A_RX, d);     check("rx_empty", d, 8'h00);

      // Underrun with ERRIE; flush bits read back as 0
      apb_write(A_STAT, 8'h30);
      apb_write(A_CTRL, 8'hC9);
      apb_read(A_CTRL, d);   check("ctrl_flush_rd", d, 8'h09);
      spi_begin();
      spi_byte(8'h11);
      spi_end();
      check("miso_udr", (m_miso_q.size() > 0) ? m_miso_q[0] : 8'h00, 8'hFF);
      apb_read(A_STAT, d);   check("udr_set", {7'd0, d[5]}, 8'h01);
      @(negedge PCLK);       check("int_udr", {7'd0, SPI_INT}, 8'h01);
      apb_write(A_STAT, 8'h20);
      @(negedge PCLK);       check("int_clr", {7'd0, SPI_INT}, 8'h00);
      apb_read(A_STAT, d);   check("udr_clr", {7'd0, d[5]}, 8'h00);
      apb_read(A_RX, d);     check("rx_11", d, 8'h11);

      // Overrun: DEPTH+1 bytes without reading
      apb_write(A_CTRL, 8'h01);
      spi_begin();
      for (int i = 1; i <= DEPTH + 1; i++) spi_byte(8'(i));
      spi_end();
      apb_read(A_STAT, d);
      check("rxfull", {7'd0, d[1]}, 8'h01);
      check("ovr", {7'd0, d[4]}, 8'h01);
      for (int i = 1; i <= DEPTH; i++) begin
         apb_read(A_RX, d);
         check("rx_order", d, 8'(i));
      end
      apb_read(A_RX, d);     check("rx_5th_lost", d, 8'h00);
      apb_write(A_STAT, 8'h30);

      // Partial frame discarded, then a clean frame
      bits5 = 8'b1011_0000;
      spi_begin();
      for (int i = 7; i >= 3; i--) spi_bit(bits5[i], 1'b0, d);
      spi_end();
      apb_read(A_STAT, d);   check("partial_no_rx", {7'd0, d[0]}, 8'h00);
      apb_write(A_TX, 8'h69);
      spi_begin();
      spi_byte(8'h96);
      spi_end();
      check("miso_69", (m_miso_q.size() > 0) ? m_miso_q[0] : 8'h00, 8'h69);
      apb_read(A_RX, d);     check("rx_96", d, 8'h96);
      apb_write(A_STAT, 8'h30);

      // Same-cycle RXDATA pop and SPI push with the RX FIFO full
      spi_begin();
      spi_byte(8'h10);
      spi_byte(8'h20);
      spi_byte(8'h30);
      spi_byte(8'h40);
      for (int i = 7; i >= 1; i--) spi_bit(1'(8'h50 >> i), 1'b0, d);
      spi_bit(1'b0, 1'b1, d);
      check("pop_conc", d, 8'h10);
      spi_end();
      apb_read(A_STAT, d);
      check("conc_full", {7'd0, d[1]}, 8'h01);
      check("conc_no_ovr", {7'd0, d[4]}, 8'h00);
      apb_read(A_RX, d);     check("conc_20", d, 8'h20);
      apb_read(A_RX, d);     check("conc_30", d, 8'h30);
      apb_read(A_RX, d);     check("conc_40", d, 8'h40);
      apb_read(A_RX, d);     check("conc_50", d, 8'h50);

      // TXIE, address aliasing, unmapped reads
      apb_write(A_CTRL, 8'h05);
      @(negedge PCLK);       check("int_txe", {7'd0, SPI_INT}, 8'h01);
      apb_write(A_TX, 8'h77);
      @(negedge PCLK);       check("int_txne", {7'd0, SPI_INT}, 8'h00);
      apb_read(8'h0F, d);    check("stat_alias_txne", {7'd0, d[2]}, 8'h00);
      apb_read(A_TX, d);     check("txdata_rd", d, 8'h00);
      apb_read(8'hF8, d);    check("unmapped_rd", d, 8'h00);
      apb_write(A_CTRL, 8'h00);
      @(negedge PCLK);       check("int_dis", {7'd0, SPI_INT}, 8'h00);

      repeat (4) @(posedge PCLK);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
